// File: rtl/text_console_ctrl.sv
// text_console_ctrl: character-stream front end for the VGA text peripheral.
// Turns characters, control codes and colour updates into single-cycle bus
// writes, and runs screen/line clears as write bursts.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_CLEAR_ALL  | writing spaces to every cell, cursor held at (0,0)
// S_IDLE       | accepting characters and colour updates
// S_CLEAR_LINE | writing spaces across the row the cursor just moved to
// S_COLOR_BG   | issuing the background-colour write after the foreground
module text_console_ctrl #(
  parameter int          COLS               = 80,
  parameter int          ROWS               = 60,
  parameter logic [63:0] VRAM_START_ADDRESS = 64'h30002,
  parameter logic [63:0] FG_ADDRESS         = 64'h30001,
  parameter logic [63:0] BG_ADDRESS         = 64'h30000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [11:0] fg_in,
  input  logic [11:0] bg_in,
  input  logic        color_valid,
  output logic        color_ready,
  output logic [63:0] address,
  output logic [63:0] data,
  output logic        write,
  output logic        busy,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row
);

  localparam logic [12:0] LP_COLS      = 13'(COLS);
  localparam logic [12:0] LP_LAST_CELL = 13'(COLS * ROWS - 1);
  localparam logic [12:0] LP_LAST_IDX  = 13'(COLS - 1);
  localparam logic [6:0]  LP_LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LP_LAST_ROW  = 6'(ROWS - 1);
  localparam logic [63:0] LP_SPACE     = 64'h20;

  typedef enum logic [1:0] {
    S_CLEAR_ALL,
    S_IDLE,
    S_CLEAR_LINE,
    S_COLOR_BG
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [12:0] r_cnt, w_cnt_nxt;
  logic [12:0] r_line_base, w_line_base_nxt;
  logic [6:0]  r_col, w_col_nxt;
  logic [5:0]  r_row, w_row_nxt;
  logic [11:0] r_bg, w_bg_nxt;
  logic [63:0] r_address, w_address_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic        r_write, w_write_nxt;

  logic [12:0] w_row_base;
  logic [12:0] w_cell;
  logic [5:0]  w_next_row;
  logic [12:0] w_next_base;
  logic        w_printable;
  logic        w_idle;
  logic        w_adv;

  assign w_idle      = (r_state == S_IDLE);
  assign w_row_base  = 13'(r_row) * LP_COLS;
  assign w_cell      = w_row_base + 13'(r_col);
  assign w_next_row  = (r_row == LP_LAST_ROW) ? 6'd0 : r_row + 6'd1;
  assign w_next_base = 13'(w_next_row) * LP_COLS;
  assign w_printable = (char_in >= 8'h20) && (char_in != 8'h7F);

  assign color_ready = w_idle;
  assign char_ready  = w_idle & ~color_valid;
  assign busy        = ~w_idle;
  assign address     = r_address;
  assign data        = r_data;
  assign write       = r_write;
  assign cursor_col  = r_col;
  assign cursor_row  = r_row;

  // Next-state, cursor and bus-write decisions for the coming edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_line_base_nxt = r_line_base;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_bg_nxt        = r_bg;
    w_address_nxt   = r_address;
    w_data_nxt      = r_data;
    w_write_nxt     = 1'b0;
    w_adv           = 1'b0;

    case (r_state)
      S_CLEAR_ALL: begin
        w_write_nxt   = 1'b1;
        w_address_nxt = VRAM_START_ADDRESS + 64'(r_cnt);
        w_data_nxt    = LP_SPACE;
        w_col_nxt     = 7'd0;
        w_row_nxt     = 6'd0;
        if (r_cnt == LP_LAST_CELL) begin
          w_cnt_nxt   = 13'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 13'd1;
        end
      end

      S_IDLE: begin
        if (color_valid) begin
          w_write_nxt   = 1'b1;
          w_address_nxt = FG_ADDRESS;
          w_data_nxt    = 64'(fg_in);
          w_bg_nxt      = bg_in;
          w_state_nxt   = S_COLOR_BG;
        end else if (char_valid) begin
          if (w_printable) begin
            w_write_nxt   = 1'b1;
            w_address_nxt = VRAM_START_ADDRESS + 64'(w_cell);
            w_data_nxt    = 64'(char_in);
            if (r_col == LP_LAST_COL) begin
              w_col_nxt = 7'd0;
              w_adv     = 1'b1;
            end else begin
              w_col_nxt = r_col + 7'd1;
            end
          end else begin
            case (char_in)
              8'h0A: begin
                w_col_nxt = 7'd0;
                w_adv     = 1'b1;
              end
              8'h0D: w_col_nxt = 7'd0;
              8'h08: begin
                // Backspace stops at column 0 rather than wrapping upward.
                if (r_col != 7'd0) begin
                  w_col_nxt     = r_col - 7'd1;
                  w_write_nxt   = 1'b1;
                  w_address_nxt = VRAM_START_ADDRESS + 64'(w_cell - 13'd1);
                  w_data_nxt    = LP_SPACE;
                end
              end
              8'h0C: begin
                w_col_nxt   = 7'd0;
                w_row_nxt   = 6'd0;
                w_cnt_nxt   = 13'd0;
                w_state_nxt = S_CLEAR_ALL;
              end
              default: ;
            endcase
          end
          if (w_adv) begin
            w_row_nxt       = w_next_row;
            w_line_base_nxt = w_next_base;
            w_cnt_nxt       = 13'd0;
            w_state_nxt     = S_CLEAR_LINE;
          end
        end
      end

      S_CLEAR_LINE: begin
        w_write_nxt   = 1'b1;
        w_address_nxt = VRAM_START_ADDRESS + 64'(r_line_base + r_cnt);
        w_data_nxt    = LP_SPACE;
        if (r_cnt == LP_LAST_IDX) begin
          w_cnt_nxt   = 13'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 13'd1;
        end
      end

      S_COLOR_BG: begin
        w_write_nxt   = 1'b1;
        w_address_nxt = BG_ADDRESS;
        w_data_nxt    = 64'(r_bg);
        w_state_nxt   = S_IDLE;
      end

      default: w_state_nxt = S_CLEAR_ALL;
    endcase
  end

  // State, cursor and bus output registers; reset restarts the full clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR_ALL;
      r_cnt       <= 13'd0;
      r_line_base <= 13'd0;
      r_col       <= 7'd0;
      r_row       <= 6'd0;
      r_bg        <= 12'd0;
      r_address   <= 64'd0;
      r_data      <= 64'd0;
      r_write     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_line_base <= w_line_base_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_bg        <= w_bg_nxt;
      r_address   <= w_address_nxt;
      r_data      <= w_data_nxt;
      r_write     <= w_write_nxt;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: the reference model is a queue of the bus
// writes the console is expected to produce, one entry per cycle.
module tb_text_console_ctrl;

  localparam int          COLS = 80;
  localparam int          ROWS = 60;
  localparam logic [63:0] VRAM = 64'h30002;
  localparam logic [63:0] FGA  = 64'h30001;
  localparam logic [63:0] BGA  = 64'h30000;

  logic        clock;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] fg_in;
  logic [11:0] bg_in;
  logic        color_valid;
  logic        color_ready;
  logic [63:0] address;
  logic [63:0] data;
  logic        write;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;

  text_console_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .fg_in       (fg_in),
    .bg_in       (bg_in),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .address     (address),
    .data        (data),
    .write       (write),
    .busy        (busy),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          v;
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t m_q[$];
  wr_t m_cur;
  int  m_col, m_row;
  bit  m_acc_chr, m_acc_col;
  int  n_checks, n_fail;
  int  ff_budget;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(bit v, logic [63:0] a, logic [63:0] d);
    wr_t w;
    w.v = v;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  function automatic logic [63:0] cell_addr(int r, int c);
    return VRAM + 64'(r * COLS + c);
  endfunction

  task automatic push_clear_all();
    for (int k = 0; k < COLS * ROWS; k++) m_q.push_back(mk(1'b1, VRAM + 64'(k), 64'h20));
  endtask

  task automatic model_reset();
    m_q.delete();
    push_clear_all();
    m_cur = mk(1'b0, 64'd0, 64'd0);
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_char(input logic [7:0] c);
    bit  adv = 1'b0;
    bit  clr = 1'b0;
    wr_t first = mk(1'b0, 64'd0, 64'd0);
    if (c >= 8'h20 && c != 8'h7F) begin
      first = mk(1'b1, cell_addr(m_row, m_col), 64'(c));
      if (m_col == COLS - 1) begin
        m_col = 0;
        adv = 1'b1;
      end else m_col++;
    end else if (c == 8'h0A) begin
      m_col = 0;
      adv = 1'b1;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        first = mk(1'b1, cell_addr(m_row, m_col), 64'h20);
      end
    end else if (c == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      clr = 1'b1;
    end
    m_q.push_back(first);
    if (adv) begin
      m_row = (m_row + 1) % ROWS;
      for (int k = 0; k < COLS; k++) m_q.push_back(mk(1'b1, cell_addr(m_row, k), 64'h20));
    end
    if (clr) push_clear_all();
  endtask

  task automatic model_edge();
    bit busy_m = (m_q.size() != 0);
    m_acc_chr = 1'b0;
    m_acc_col = 1'b0;
    if (!busy_m && color_valid) begin
      m_acc_col = 1'b1;
      m_q.push_back(mk(1'b1, FGA, 64'(fg_in)));
      m_q.push_back(mk(1'b1, BGA, 64'(bg_in)));
    end else if (!busy_m && char_valid) begin
      m_acc_chr = 1'b1;
      model_char(char_in);
    end
    if (m_q.size() != 0) m_cur = m_q.pop_front();
    else m_cur = mk(1'b0, 64'd0, 64'd0);
  endtask

  task automatic check_outputs();
    bit busy_m = (m_q.size() != 0);
    check("write", 64'(write), 64'(m_cur.v));
    if (m_cur.v) begin
      check("address", address, m_cur.a);
      check("data", data, m_cur.d);
    end
    check("busy", 64'(busy), 64'(busy_m));
    check("char_ready", 64'(char_ready), 64'(!busy_m && !color_valid));
    check("color_ready", 64'(color_ready), 64'(!busy_m));
    check("cursor_col", 64'(cursor_col), 64'(m_col));
    check("cursor_row", 64'(cursor_row), 64'(m_row));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic timeout_fail(input string tag);
    n_fail++;
    $display("FAIL timeout %s: got no completion expected completion (t=%0t)", tag, $time);
  endtask

  task automatic send_char(input logic [7:0] c);
    bit done = 1'b0;
    char_in = c;
    char_valid = 1'b1;
    for (int i = 0; i < 6000 && !done; i++) begin
      step();
      if (m_acc_chr) done = 1'b1;
    end
    char_valid = 1'b0;
    if (!done) timeout_fail("send_char");
  endtask

  task automatic send_both(input logic [7:0] c, input logic [11:0] fg, input logic [11:0] bg);
    bit done = 1'b0;
    char_in = c;
    fg_in = fg;
    bg_in = bg;
    char_valid = 1'b1;
    color_valid = 1'b1;
    for (int i = 0; i < 6000 && !done; i++) begin
      step();
      if (m_acc_col) color_valid = 1'b0;
      if (m_acc_chr) done = 1'b1;
    end
    char_valid = 1'b0;
    color_valid = 1'b0;
    if (!done) timeout_fail("send_both");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      if (m_q.size() == 0) done = 1'b1;
      else step();
    end
    if (!done) timeout_fail("wait_idle");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_write"}, 64'(write), 64'd0);
    check({tag, "_address"}, address, 64'd0);
    check({tag, "_data"}, data, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_char_ready"}, 64'(char_ready), 64'd0);
    check({tag, "_color_ready"}, 64'(color_ready), 64'd0);
    check({tag, "_col"}, 64'(cursor_col), 64'd0);
    check({tag, "_row"}, 64'(cursor_row), 64'd0);
  endtask

  function automatic logic [7:0] pick_char();
    int r = $urandom_range(99);
    logic [7:0] c;
    if (r < 70) begin
      do c = 8'($urandom_range(255, 32)); while (c == 8'h7F);
    end else if (r < 78) c = 8'h0A;
    else if (r < 83) c = 8'h0D;
    else if (r < 93) c = 8'h08;
    else if (r < 98) begin
      do c = 8'($urandom_range(31, 0));
      while (c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C);
      if ($urandom_range(3) == 0) c = 8'h7F;
    end else if (ff_budget > 0) begin
      ff_budget--;
      c = 8'h0C;
    end else c = 8'h61;
    return c;
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    ff_budget = 1;
    reset = 1'b1;
    char_in = 8'h00;
    char_valid = 1'b0;
    fg_in = 12'h000;
    bg_in = 12'h000;
    color_valid = 1'b0;
    model_reset();

    repeat (3) @(negedge clock);
    check_reset_values("reset");
    check_outputs();
    reset = 1'b0;
    wait_idle();

    send_char(8'h41);
    send_char(8'h42);
    wait_idle();

    send_char(8'h0D);
    for (int i = 0; i < 5; i++) send_char(8'h30 + 8'(i));
    send_char(8'h0A);
    wait_idle();

    send_both(8'h43, 12'h0F0, 12'h00F);
    wait_idle();

    send_char(8'h0D);
    send_char(8'h08);
    send_char(8'h7F);
    send_char(8'h01);
    send_char(8'h1B);

    for (int i = 0; i < ROWS && m_row != ROWS - 1; i++) send_char(8'h0A);
    wait_idle();
    for (int i = 0; i < COLS && m_col != COLS - 1; i++) send_char(8'h78);
    send_char(8'h5A);
    wait_idle();

    for (int i = 0; i < 6000; i++) begin
      if (!char_valid && $urandom_range(3) != 0) begin
        char_in = pick_char();
        char_valid = 1'b1;
      end
      if (!color_valid && $urandom_range(19) == 0) begin
        fg_in = 12'($urandom);
        bg_in = 12'($urandom);
        color_valid = 1'b1;
      end
      step();
      if (m_acc_chr) char_valid = 1'b0;
      if (m_acc_col) color_valid = 1'b0;
    end
    for (int i = 0; i < 6000 && (char_valid || color_valid); i++) begin
      step();
      if (m_acc_chr) char_valid = 1'b0;
      if (m_acc_col) color_valid = 1'b0;
    end
    if (char_valid || color_valid) timeout_fail("random_drain");
    char_valid = 1'b0;
    color_valid = 1'b0;
    wait_idle();

    send_char(8'h0C);
    wait_idle();
    send_char(8'h0A);
    send_char(8'h0A);
    wait_idle();
    for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i));
    send_char(8'h08);
    send_char(8'h0A);
    repeat (20) step();

    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    wait_idle();
    send_char(8'h51);
    wait_idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
